// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl
// Key front end and run/pause/idle sequencer for the stopwatch counter.
// Two raw active-low push-buttons are synchronised, debounced and turned into
// single-cycle press events. A small FSM converts those events into a
// `running` level and a one-cycle `clear` pulse for the stopwatch.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active low
//   key_start_n  raw start/stop button, 0 = pressed, asynchronous to clk
//   key_clear_n  raw clear button, 0 = pressed, asynchronous to clk
//   running      1 while the stopwatch should count (registered)
//   clear        one-cycle active-high pulse that zeroes the stopwatch
//   state        current FSM state for LEDs/debug (IDLE=0, RUN=1, PAUSE=2)
//
// state | meaning
// IDLE  | stopwatch stopped and zeroed, waiting for start
// RUN   | stopwatch counting
// PAUSE | stopwatch stopped, value held; clear returns to IDLE
module cronometro_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic       running,
  output logic       clear,
  output logic [1:0] state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Bit 0 = start key, bit 1 = clear key.
  logic [1:0] key_raw;
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] db_dly_q, db_dly_d;
  logic [1:0] press_q, press_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_t state_q, state_d;
  logic   running_q, running_d;
  logic   clear_q, clear_d;
  logic   start_ev, clear_ev;

  assign key_raw = {key_clear_n, key_start_n};

  always_comb begin
    s1_d     = key_raw;
    s2_d     = s1_q;
    db_dly_d = db_q;
    // Press fires one cycle after the debounced level falls; releases are ignored.
    press_d  = db_dly_q & ~db_q;
    db_d     = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      // Any cycle where the synchronised key agrees with db restarts the count.
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 2'b11;
      s2_q     <= 2'b11;
      db_q     <= 2'b11;
      db_dly_q <= 2'b11;
      press_q  <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign start_ev = press_q[0];
  assign clear_ev = press_q[1];

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_ev) begin
          clear_d = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Clear is deliberately ignored while counting.
        if (start_ev) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_ev) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      default: begin
        // Unused encoding: recover to a known, zeroed stopwatch.
        state_d = IDLE;
        clear_d = 1'b1;
      end
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      clear_q   <= clear_d;
    end
  end

  assign running = running_q;
  assign clear   = clear_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
module tb_cronometro_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_start_n;
  logic       key_clear_n;
  logic       running;
  logic       clear;
  logic [1:0] state;

  always #5 clk = ~clk;

  cronometro_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .running     (running),
    .clear       (clear),
    .state       (state)
  );

  typedef struct {
    int cyc;
    int st;
    bit run;
    bit clr;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: raw key history per key; a key's debounced level flips
  // when the synchronised samples over the last DB cycles all disagree with it.
  bit hist_s[$];
  bit hist_c[$];
  bit db_m[2];
  bit fell_m[2];
  bit press_m[2];
  int st_m = 0;
  bit run_m = 0;

  function automatic bit all_differ(input bit h[$], input bit lvl);
    for (int i = 0; i < DB; i++) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clear();
    hist_s.delete();
    hist_c.delete();
    for (int i = 0; i < DB + 1; i++) begin
      hist_s.push_back(1'b1);
      hist_c.push_back(1'b1);
    end
    db_m    = '{1'b1, 1'b1};
    fell_m  = '{1'b0, 1'b0};
    press_m = '{1'b0, 1'b0};
    st_m    = 0;
    run_m   = 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int nst;
    bit nrun, nclr, se, ce;
    if (!reset) begin
      if (st_m != 0 || run_m) exp_q.push_back('{cyc, 0, 1'b0, 1'b0});
      model_clear();
    end else begin
      cyc++;
      se   = press_m[0];
      ce   = press_m[1];
      nst  = st_m;
      nclr = 1'b0;
      case (st_m)
        0: if (ce) nclr = 1'b1; else if (se) nst = 1;
        1: if (se) nst = 2;
        2: if (ce) begin nst = 0; nclr = 1'b1; end else if (se) nst = 1;
        default: begin nst = 0; nclr = 1'b1; end
      endcase
      nrun    = (nst == 1);
      press_m = fell_m;
      fell_m  = '{1'b0, 1'b0};
      if (all_differ(hist_s, db_m[0])) begin fell_m[0] = db_m[0]; db_m[0] = ~db_m[0]; end
      if (all_differ(hist_c, db_m[1])) begin fell_m[1] = db_m[1]; db_m[1] = ~db_m[1]; end
      hist_s.push_back(key_start_n);
      void'(hist_s.pop_front());
      hist_c.push_back(key_clear_n);
      void'(hist_c.pop_front());
      if (nst != st_m || nrun != run_m || nclr) exp_q.push_back('{cyc, nst, nrun, nclr});
      st_m  = nst;
      run_m = nrun;
    end
  end

  // Monitor: any change of state/running, or a clear pulse, is a DUT event.
  int last_st = 0;
  bit last_run = 1'b0;
  always @(negedge clk) begin : monitor
    rec_t e;
    if (int'(state) != last_st || running != last_run || clear) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got state=%0d running=%0b clear=%0b, expected no event",
                 cyc, state, running, clear);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.st != int'(state) || e.run != running || e.clr != clear) begin
          errors++;
          $display("FAIL event got cyc=%0d state=%0d running=%0b clear=%0b, expected cyc=%0d state=%0d running=%0b clear=%0b",
                   cyc, state, running, clear, e.cyc, e.st, e.run, e.clr);
        end
      end
    end
    last_st  = int'(state);
    last_run = running;
  end

  task automatic hold(input bit s, input bit c, input int n);
    key_start_n = s;
    key_clear_n = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit c);
    hold(s, c, 10);
    hold(1'b1, 1'b1, 10);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (running !== 1'b0 || clear !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL %s got state=%0d running=%0b clear=%0b, expected state=0 running=0 clear=0",
               name, state, running, clear);
    end
  endtask

  initial begin
    reset       = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b1;
    hold(1'b1, 1'b1, 5);

    // Bounce rejection: toggles every 2 cycles never reach the debounce count.
    for (int i = 0; i < 20; i++) hold(i[0], 1'b1, 2);
    hold(1'b1, 1'b1, 10);

    // Latency / full cycle.
    press(1'b0, 1'b1);   // IDLE -> RUN
    press(1'b0, 1'b1);   // RUN -> PAUSE
    press(1'b1, 1'b0);   // PAUSE -> IDLE with clear
    press(1'b0, 1'b1);   // IDLE -> RUN
    press(1'b1, 1'b0);   // ignored in RUN
    press(1'b0, 1'b0);   // RUN -> PAUSE, no clear
    press(1'b0, 1'b0);   // PAUSE -> IDLE with clear
    hold(1'b0, 1'b0, 100); // IDLE: one clear only
    hold(1'b1, 1'b1, 10);
    press(1'b0, 1'b1);   // IDLE -> RUN

    // Reset mid-operation with a partial debounce count pending.
    hold(1'b0, 1'b1, 3);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_idle("reset_midop");
    key_start_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    reset = 1'b1;
    hold(1'b1, 1'b1, 20);

    // Randomised key activity including bounces and simultaneous presses.
    for (int i = 0; i < 400; i++)
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    hold(1'b1, 1'b1, 30);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
